sub16_kpg_pl: RTL and testbench

//  Pipelined W-bit subtractor: diff = a - b - brw_in, with borrow-out.

---
 rtl/kpg_pkg.sv | 21 ++
 rtl/kpg_cell.sv | 12 +
 rtl/sub16_kpg_pl.sv | 79 +++++++
 tb/tb_sub16_kpg_pl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/kpg_pkg.sv
// Kill/propagate/generate encoding and prefix operators, shared by the KPG adder and subtractor.
package kpg_pkg;

   typedef logic [1:0] kpg_t;

   localparam kpg_t KPG_K = 2'b00;
   localparam kpg_t KPG_P = 2'b01;
   localparam kpg_t KPG_G = 2'b11;

   // hi is the more significant span; 2'b10 falls through as propagate
   function automatic kpg_t kpg_combine(kpg_t hi, kpg_t lo);
      return (hi == KPG_K || hi == KPG_G) ? hi : lo;
   endfunction

   function automatic kpg_t kpg_of(logic x, logic y);
      if (x & y)      return KPG_G;
      else if (x | y) return KPG_P;
      else            return KPG_K;
   endfunction

endpackage

// File: rtl/kpg_cell.sv
// Combinational prefix node: merges a high span with the span directly below it.
module kpg_cell
   import kpg_pkg::*;
(
   input  kpg_t hi,
   input  kpg_t lo,
   output kpg_t o
);

   assign o = kpg_combine(hi, lo);

endmodule

// File: rtl/sub16_kpg_pl.sv
// Pipelined a - b - brw_in as a + ~b + ~brw_in over a Kogge-Stone KPG tree, one level per stage.
module sub16_kpg_pl
   import kpg_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         in_valid,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         brw_in,
   output logic         out_valid,
   output logic [W-1:0] diff,
   output logic         brw_out
);

   localparam int LEVELS = $clog2(W);
   localparam int STAGES = LEVELS + 1;

   kpg_t [LEVELS:0][W-1:0] kpg_q;
   kpg_t [LEVELS:1][W-1:0] kpg_nxt;
   kpg_t [LEVELS:0]        cin_q;
   logic [LEVELS:0][W-1:0] p_q;
   logic [STAGES:0]        vld_pipe;
   kpg_t [W-1:0]           res;
   logic [W-1:0]           carry;

   for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
      localparam int S = 1 << (l - 1);
      for (genvar i = 0; i < W; i++) begin : g_bit
         if (i >= S) begin : g_tree
            kpg_cell u_cell (.hi(kpg_q[l-1][i]), .lo(kpg_q[l-1][i-S]), .o(kpg_nxt[l][i]));
         end else if (i == S - 1) begin : g_cin
            kpg_cell u_cell (.hi(kpg_q[l-1][i]), .lo(cin_q[l-1]), .o(kpg_nxt[l][i]));
         end else begin : g_pass
            assign kpg_nxt[l][i] = kpg_q[l-1][i];
         end
      end
   end

   // After the last level every bit spans [0..i]; folding in cin resolves the
   // top bit as well, which the tree alone never reaches.
   for (genvar i = 0; i < W; i++) begin : g_res
      kpg_cell u_cell (.hi(kpg_q[LEVELS][i]), .lo(cin_q[LEVELS]), .o(res[i]));
      if (i == 0) begin : g_c0
         assign carry[i] = (cin_q[LEVELS] == KPG_G);
      end else begin : g_ci
         assign carry[i] = (res[i-1] == KPG_G);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kpg_q    <= '0;
         cin_q    <= '0;
         p_q      <= '0;
         vld_pipe <= '0;
         diff     <= '0;
         brw_out  <= 1'b0;
      end else if (en) begin
         vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
         for (int i = 0; i < W; i++) kpg_q[0][i] <= kpg_of(a[i], ~b[i]);
         cin_q[0] <= brw_in ? KPG_K : KPG_G;
         p_q[0]   <= a ^ ~b;
         for (int l = 1; l <= LEVELS; l++) begin
            kpg_q[l] <= kpg_nxt[l];
            cin_q[l] <= cin_q[l-1];
            p_q[l]   <= p_q[l-1];
         end
         diff    <= p_q[LEVELS] ^ carry;
         brw_out <= (res[W-1] != KPG_G);
      end
   end

   assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_sub16_kpg_pl.sv
// Scoreboard bench for sub16_kpg_pl: expected {brw_out,diff} queued at issue, popped at output.
module tb_sub16_kpg_pl;

   logic        clk = 1'b0;
   logic        rst_n, en, in_valid, brw_in;
   logic [15:0] a, b;
   logic        out_valid, brw_out;
   logic [15:0] diff;

   int          checks = 0;
   int          errors = 0;
   logic [16:0] sb[$];

   always #5 clk = ~clk;

   sub16_kpg_pl #(.W(16)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
      .a(a), .b(b), .brw_in(brw_in),
      .out_valid(out_valid), .diff(diff), .brw_out(brw_out)
   );

   // One clock: drive, push accepted op's reference result, sample #1 after the edge.
   task automatic step(input bit e, input bit v, input logic [15:0] ai, input logic [15:0] bi,
                       input logic bri, output bit got, output logic [16:0] exp);
      en = e; in_valid = v; a = ai; b = bi; brw_in = bri;
      @(posedge clk);
      if (rst_n && e && v) sb.push_back({1'b0, ai} - {1'b0, bi} - {16'b0, bri});
      #1;
      got = rst_n && e && out_valid;
      exp = 'x;
      if (got && sb.size() > 0) exp = sb.pop_front();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; a = '0; b = '0; brw_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      checks++; if (diff !== 16'h0) begin errors++; $display("FAIL reset_diff: got %h want 0000", diff); end
      checks++; if (brw_out !== 1'b0) begin errors++; $display("FAIL reset_brw: got %b want 0", brw_out); end
      rst_n = 1'b1;
      sb.delete();
   endtask

   task automatic test_basic();
      bit got; logic [16:0] exp; int first = -1;
      for (int k = 0; k < 12; k++) begin
         if (k == 0) step(1, 1, 16'h9999, 16'h7777, 1'b0, got, exp);
         else        step(1, 0, 16'h0, 16'h0, 1'b0, got, exp);
         if (got) begin
            checks++;
            if (first < 0) first = k;
            if ({brw_out, diff} !== exp || {brw_out, diff} !== 17'h02222) begin
               errors++; $display("FAIL basic_data: got %h want %h", {brw_out, diff}, exp);
            end
         end
      end
      checks++; if (first != 5) begin errors++; $display("FAIL basic_latency: got %0d want 5", first); end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL basic_drain: got %0d left want 0", sb.size()); end
   endtask

   task automatic test_corners();
      bit got; logic [16:0] exp; int n = 0;
      logic [15:0] ta[5] = '{16'h0000, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234};
      logic [15:0] tb[5] = '{16'h0001, 16'h1234, 16'hFFFF, 16'h0000, 16'h1234};
      logic        tc[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [16:0] tr[5] = '{17'h1FFFF, 17'h1FFFF, 17'h10000, 17'h0FFFF, 17'h00000};
      for (int k = 0; k < 16; k++) begin
         if (k < 5) step(1, 1, ta[k], tb[k], tc[k], got, exp);
         else       step(1, 0, 16'h0, 16'h0, 1'b0, got, exp);
         if (got) begin
            checks++;
            if ({brw_out, diff} !== exp || (n < 5 && {brw_out, diff} !== tr[n])) begin
               errors++; $display("FAIL corner_%0d: got %h want %h", n, {brw_out, diff}, exp);
            end
            n++;
         end
      end
      checks++; if (n != 5) begin errors++; $display("FAIL corner_count: got %0d want 5", n); end
   endtask

   task automatic test_back_to_back();
      bit got; logic [16:0] exp; int first = -1, last = -1, n = 0;
      for (int k = 0; k < 28; k++) begin
         if (k < 16) begin
            logic [15:0] iv;
            iv = 16'(k);
            step(1, 1, iv, 16'(3 * k), iv[0], got, exp);
         end else step(1, 0, 16'h0, 16'h0, 1'b0, got, exp);
         if (got) begin
            checks++;
            if (first < 0) first = k;
            last = k;
            if ({brw_out, diff} !== exp || brw_out !== (n > 0)) begin
               errors++; $display("FAIL b2b_%0d: got %h want %h", n, {brw_out, diff}, exp);
            end
            n++;
         end
      end
      checks++;
      if (n != 16 || last - first != 15) begin
         errors++; $display("FAIL b2b_stream: got %0d outputs over %0d cycles want 16 over 16", n, last - first + 1);
      end
   endtask

   task automatic test_bubble();
      bit got; logic [16:0] exp; logic [2:0] pat = '0;
      for (int k = 0; k < 12; k++) begin
         case (k)
            0:       step(1, 1, 16'd8, 16'd3, 1'b0, got, exp);
            1:       step(1, 0, 16'hDEAD, 16'hBEEF, 1'b1, got, exp);
            2:       step(1, 1, 16'd3, 16'd8, 1'b0, got, exp);
            default: step(1, 0, 16'h0, 16'h0, 1'b0, got, exp);
         endcase
         if (k >= 5 && k <= 7) pat[7-k] = out_valid;
         if (got) begin
            checks++;
            if ({brw_out, diff} !== exp) begin
               errors++; $display("FAIL bubble_data: got %h want %h", {brw_out, diff}, exp);
            end
         end
      end
      checks++; if (pat !== 3'b101) begin errors++; $display("FAIL bubble_valid: got %b want 101", pat); end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL bubble_drain: got %0d left want 0", sb.size()); end
   endtask

   task automatic test_stall();
      bit got; logic [16:0] exp; logic [17:0] snap = '0; int n = 0, resume = -1;
      for (int k = 0; k < 20; k++) begin
         if (k < 5)       step(1, 1, 16'(100 + k), 16'(7 * k), k[0], got, exp);
         else if (k == 5) step(1, 0, 16'h0, 16'h0, 1'b0, got, exp);
         else if (k < 9)  step(0, 1, 16'h5555, 16'hAAAA, 1'b1, got, exp);
         else             step(1, 0, 16'h0, 16'h0, 1'b0, got, exp);
         if (k == 5) snap = {out_valid, brw_out, diff};
         if (k >= 6 && k <= 8) begin
            checks++;
            if ({out_valid, brw_out, diff} !== snap) begin
               errors++; $display("FAIL stall_hold: got %h want %h", {out_valid, brw_out, diff}, snap);
            end
         end
         if (got) begin
            checks++;
            if (k > 8 && resume < 0) resume = k;
            if ({brw_out, diff} !== exp) begin
               errors++; $display("FAIL stall_data_%0d: got %h want %h", n, {brw_out, diff}, exp);
            end
            n++;
         end
      end
      checks++; if (resume != 9) begin errors++; $display("FAIL stall_latency: got %0d want 9", resume); end
      checks++;
      if (n != 5 || sb.size() != 0) begin
         errors++; $display("FAIL stall_count: got %0d outputs %0d left want 5 and 0", n, sb.size());
      end
   endtask

   task automatic test_reset_mid();
      bit got; logic [16:0] exp; int first = -1;
      for (int k = 0; k < 7; k++) step(1, 1, 16'(k * 1000), 16'(k * 77), 1'b1, got, exp);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, brw_out, diff} !== 18'h0) begin
         errors++; $display("FAIL midreset_clear: got %h want 00000", {out_valid, brw_out, diff});
      end
      sb.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (k == 0) step(1, 1, 16'h4321, 16'h1234, 1'b0, got, exp);
         else        step(1, 0, 16'h0, 16'h0, 1'b0, got, exp);
         if (got) begin
            checks++;
            if (first < 0) first = k;
            if ({brw_out, diff} !== exp) begin
               errors++; $display("FAIL midreset_data: got %h want %h", {brw_out, diff}, exp);
            end
         end
      end
      checks++; if (first != 5) begin errors++; $display("FAIL midreset_latency: got %0d want 5", first); end
   endtask

   task automatic test_random();
      bit got; logic [16:0] exp; int issued = 0, cyc = 0, bad = 0;
      while (issued < 10000 && cyc < 40000) begin
         bit e, v;
         e = ($urandom_range(0, 3) != 0);
         v = ($urandom_range(0, 3) != 0);
         step(e, v, 16'($urandom), 16'($urandom), 1'($urandom), got, exp);
         if (e && v) issued++;
         cyc++;
         if (got) begin
            checks++;
            if ({brw_out, diff} !== exp) begin
               errors++; bad++;
               if (bad < 10) $display("FAIL random: got %h want %h", {brw_out, diff}, exp);
            end
         end
      end
      for (int k = 0; k < 10; k++) begin
         step(1, 0, 16'h0, 16'h0, 1'b0, got, exp);
         if (got) begin
            checks++;
            if ({brw_out, diff} !== exp) begin
               errors++; $display("FAIL random_tail: got %h want %h", {brw_out, diff}, exp);
            end
         end
      end
      checks++;
      if (issued != 10000 || sb.size() != 0) begin
         errors++; $display("FAIL random_drain: got %0d issued %0d left want 10000 and 0", issued, sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_corners();
      test_back_to_back();
      test_bubble();
      test_stall();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
